// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: game-level sequencer for the pong ball datapath.
// Holds the ball at centre while idle, counts down a serve, releases the
// ball for play, judges paddle misses once per frame, keeps both scores and
// declares a winner. All outputs are registers.
module pong_game_ctrl #(
  parameter int BALL_SIZE      = 10,
  parameter int LEFT_BOUNDARY  = 3,
  parameter int RIGHT_BOUNDARY = 637,
  parameter int PADDLE_HEIGHT  = 64,
  parameter int SERVE_FRAMES   = 60,
  parameter int POINT_FRAMES   = 30,
  parameter int WIN_SCORE      = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        start,
  input  logic [10:0] ball_pos_x,
  input  logic [10:0] ball_pos_y,
  input  logic [10:0] paddle_left_y,
  input  logic [10:0] paddle_right_y,
  output logic        ball_hold,
  output logic        ball_run,
  output logic        serve_dir,
  output logic [3:0]  score_left,
  output logic [3:0]  score_right,
  output logic [2:0]  state,
  output logic        game_over,
  output logic        winner
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SERVE     = 3'd1,
    PLAY      = 3'd2,
    POINT     = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  // One down-counter is shared by SERVE and POINT, so size it for the longer.
  localparam int CNT_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [11:0] BS12    = 12'(BALL_SIZE);
  localparam logic [11:0] PH12    = 12'(PADDLE_HEIGHT);
  localparam logic [11:0] LB12    = 12'(LEFT_BOUNDARY);
  localparam logic [11:0] RB12    = 12'(RIGHT_BOUNDARY);
  localparam logic [3:0]  WIN4    = 4'(WIN_SCORE);
  localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_FRAMES);
  localparam logic [CNT_W-1:0] POINT_LOAD = CNT_W'(POINT_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             start_q;
  logic             start_edge;

  // Geometry is evaluated at 12 bits so ball/paddle sums can never wrap.
  logic [11:0] ball_x12;
  logic [11:0] ball_y12;
  logic [11:0] paddle_y12 [2];
  logic [1:0]  ovl;
  logic        left_miss;
  logic        right_miss;

  assign ball_x12      = {1'b0, ball_pos_x};
  assign ball_y12      = {1'b0, ball_pos_y};
  assign paddle_y12[0] = {1'b0, paddle_left_y};
  assign paddle_y12[1] = {1'b0, paddle_right_y};

  // Vertical overlap of the ball with each paddle (0 = left, 1 = right).
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ovl
      assign ovl[gi] = ((ball_y12 + BS12) > paddle_y12[gi]) &&
                       (ball_y12 < (paddle_y12[gi] + PH12));
    end
  endgenerate

  assign left_miss  = (ball_x12 <= LB12) && !ovl[0];
  assign right_miss = ((ball_x12 + BS12) >= RB12) && !ovl[1];
  assign start_edge = start && !start_q;

  assign state = state_reg;

  // Game FSM with registered outputs; each branch sets the outputs of the
  // state it enters so hold/run always track the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      start_q     <= 1'b0;
      ball_hold   <= 1'b1;
      ball_run    <= 1'b0;
      serve_dir   <= 1'b1;
      score_left  <= 4'd0;
      score_right <= 4'd0;
      game_over   <= 1'b0;
      winner      <= 1'b0;
    end else begin
      start_q <= start;
      case (state_reg)
        IDLE: begin
          if (start_edge) begin
            state_reg <= SERVE;
            cnt_reg   <= SERVE_LOAD;
          end
        end

        SERVE: begin
          if (frame_tick) begin
            cnt_reg <= cnt_reg - CNT_ONE;
            if (cnt_reg == CNT_ONE) begin
              state_reg <= PLAY;
              ball_hold <= 1'b0;
              ball_run  <= 1'b1;
            end
          end
        end

        PLAY: begin
          // Left miss takes priority if both sides miss on the same tick.
          if (frame_tick && (left_miss || right_miss)) begin
            state_reg <= POINT;
            cnt_reg   <= POINT_LOAD;
            ball_hold <= 1'b1;
            ball_run  <= 1'b0;
            if (left_miss) begin
              score_right <= score_right + 4'd1;
              serve_dir   <= 1'b0;
            end else begin
              score_left <= score_left + 4'd1;
              serve_dir  <= 1'b1;
            end
          end
        end

        POINT: begin
          if (frame_tick) begin
            if (cnt_reg == CNT_ONE) begin
              if (score_left == WIN4 || score_right == WIN4) begin
                state_reg <= GAME_OVER;
                cnt_reg   <= cnt_reg - CNT_ONE;
                game_over <= 1'b1;
                winner    <= (score_right == WIN4);
              end else begin
                state_reg <= SERVE;
                cnt_reg   <= SERVE_LOAD;
              end
            end else begin
              cnt_reg <= cnt_reg - CNT_ONE;
            end
          end
        end

        GAME_OVER: begin
          if (start_edge) begin
            state_reg   <= SERVE;
            cnt_reg     <= SERVE_LOAD;
            score_left  <= 4'd0;
            score_right <= 4'd0;
            serve_dir   <= 1'b1;
            game_over   <= 1'b0;
          end
        end

        default: begin
          state_reg <= IDLE;
          ball_hold <= 1'b1;
          ball_run  <= 1'b0;
          game_over <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: the driver pushes the expected output
// snapshot after each stimulus cycle, a monitor pops and compares on the
// falling clock edge.
module tb_pong_game_ctrl;

  localparam int SERVE_N = 4;
  localparam int POINT_N = 3;
  localparam int WIN_N   = 2;

  localparam logic [2:0] S_IDLE = 3'd0, S_SERVE = 3'd1, S_PLAY = 3'd2,
                         S_POINT = 3'd3, S_GOVER = 3'd4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        frame_tick = 1'b0;
  logic        start = 1'b0;
  logic [10:0] ball_pos_x = 11'd320;
  logic [10:0] ball_pos_y = 11'd240;
  logic [10:0] paddle_left_y = 11'd200;
  logic [10:0] paddle_right_y = 11'd200;
  logic        ball_hold, ball_run, serve_dir, game_over, winner;
  logic [3:0]  score_left, score_right;
  logic [2:0]  state;

  pong_game_ctrl #(
    .BALL_SIZE(10), .LEFT_BOUNDARY(3), .RIGHT_BOUNDARY(637), .PADDLE_HEIGHT(64),
    .SERVE_FRAMES(SERVE_N), .POINT_FRAMES(POINT_N), .WIN_SCORE(WIN_N)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
    .ball_pos_x(ball_pos_x), .ball_pos_y(ball_pos_y),
    .paddle_left_y(paddle_left_y), .paddle_right_y(paddle_right_y),
    .ball_hold(ball_hold), .ball_run(ball_run), .serve_dir(serve_dir),
    .score_left(score_left), .score_right(score_right), .state(state),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       hold;
    logic       run;
    logic       dir;
    logic [3:0] sl;
    logic [3:0] sr;
    logic       go;
    logic       win;
  } snap_t;

  snap_t exp_q[$];
  string name_q[$];
  int    vec_cnt  = 0;
  int    miss_cnt = 0;

  task automatic expect_out(input string nm, input logic [2:0] st, input logic hold,
                            input logic run, input logic dir, input logic [3:0] sl,
                            input logic [3:0] sr, input logic go, input logic win);
    snap_t s;
    s = '{st: st, hold: hold, run: run, dir: dir, sl: sl, sr: sr, go: go, win: win};
    exp_q.push_back(s);
    name_q.push_back(nm);
  endtask

  // One stimulus cycle: inputs settle, rising edge, then release frame_tick.
  task automatic cyc(input logic ft);
    frame_tick = ft;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
  endtask

  // Monitor: compare every pending expectation on the falling edge.
  initial begin
    snap_t e, a;
    string nm;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = '{st: state, hold: ball_hold, run: ball_run, dir: serve_dir,
               sl: score_left, sr: score_right, go: game_over, win: winner};
        vec_cnt++;
        if (a !== e) begin
          miss_cnt++;
          $display("FAIL %s: got st=%0d hold=%b run=%b dir=%b sl=%0d sr=%0d go=%b win=%b, expected st=%0d hold=%b run=%b dir=%b sl=%0d sr=%0d go=%b win=%b",
                   nm, a.st, a.hold, a.run, a.dir, a.sl, a.sr, a.go, a.win,
                   e.st, e.hold, e.run, e.dir, e.sl, e.sr, e.go, e.win);
        end else begin
          $display("ok   %s: st=%0d hold=%b run=%b dir=%b sl=%0d sr=%0d go=%b win=%b",
                   nm, a.st, a.hold, a.run, a.dir, a.sl, a.sr, a.go, a.win);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset_values", S_IDLE, 1, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;

    // Frame ticks in IDLE do nothing.
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      expect_out("idle_tick", S_IDLE, 1, 0, 1, 0, 0, 0, 0);
    end

    // Start pulse enters SERVE.
    start = 1'b1;
    cyc(0);
    expect_out("start_to_serve", S_SERVE, 1, 0, 1, 0, 0, 0, 0);
    start = 1'b0;
    cyc(0);
    // A start edge in SERVE is ignored; no frame_tick means no countdown.
    start = 1'b1;
    cyc(0);
    expect_out("serve_start_ignored", S_SERVE, 1, 0, 1, 0, 0, 0, 0);
    start = 1'b0;

    // Serve countdown: exactly SERVE_N ticks.
    for (int i = 1; i < SERVE_N; i++) begin
      cyc(1);
      expect_out("serve_count", S_SERVE, 1, 0, 1, 0, 0, 0, 0);
    end
    cyc(1);
    expect_out("serve_to_play", S_PLAY, 0, 1, 1, 0, 0, 0, 0);

    // Left side: hit with overlapping paddle.
    ball_pos_x = 11'd3; ball_pos_y = 11'd100; paddle_left_y = 11'd95;
    cyc(1);
    expect_out("left_hit", S_PLAY, 0, 1, 1, 0, 0, 0, 0);
    // Just inside the left boundary, paddle far away: not a miss.
    ball_pos_x = 11'd4; paddle_left_y = 11'd200;
    cyc(1);
    expect_out("left_x4_no_miss", S_PLAY, 0, 1, 1, 0, 0, 0, 0);
    // Miss condition without frame_tick is not evaluated.
    ball_pos_x = 11'd3;
    cyc(0);
    expect_out("miss_no_tick", S_PLAY, 0, 1, 1, 0, 0, 0, 0);
    cyc(1);
    expect_out("left_miss", S_POINT, 1, 0, 0, 0, 1, 0, 0);

    for (int i = 1; i < POINT_N; i++) begin
      cyc(1);
      expect_out("point_count", S_POINT, 1, 0, 0, 0, 1, 0, 0);
    end
    cyc(1);
    expect_out("point_to_serve", S_SERVE, 1, 0, 0, 0, 1, 0, 0);
    ball_pos_x = 11'd320;
    for (int i = 0; i < SERVE_N; i++) cyc(1);
    expect_out("play_again", S_PLAY, 0, 1, 0, 0, 1, 0, 0);

    // Right side: one pixel short of the goal line is not a miss.
    ball_pos_x = 11'd626; ball_pos_y = 11'd50; paddle_right_y = 11'd300;
    cyc(1);
    expect_out("right_x626_no_miss", S_PLAY, 0, 1, 0, 0, 1, 0, 0);
    ball_pos_x = 11'd627;
    cyc(1);
    expect_out("right_miss_1", S_POINT, 1, 0, 1, 1, 1, 0, 0);
    for (int i = 0; i < POINT_N; i++) cyc(1);
    expect_out("point_to_serve_2", S_SERVE, 1, 0, 1, 1, 1, 0, 0);
    for (int i = 0; i < SERVE_N; i++) cyc(1);
    expect_out("play_3", S_PLAY, 0, 1, 1, 1, 1, 0, 0);

    // Right hit with overlap, then second right miss.
    paddle_right_y = 11'd40;
    cyc(1);
    expect_out("right_hit", S_PLAY, 0, 1, 1, 1, 1, 0, 0);
    paddle_right_y = 11'd300;
    cyc(1);
    expect_out("right_miss_2", S_POINT, 1, 0, 1, 2, 1, 0, 0);

    // Hold start high through GAME_OVER entry.
    start = 1'b1;
    for (int i = 1; i < POINT_N; i++) begin
      cyc(1);
      expect_out("point_count_2", S_POINT, 1, 0, 1, 2, 1, 0, 0);
    end
    cyc(1);
    expect_out("game_over", S_GOVER, 1, 0, 1, 2, 1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      expect_out("game_over_frozen", S_GOVER, 1, 0, 1, 2, 1, 1, 0);
    end
    start = 1'b0;
    cyc(0);
    expect_out("start_dropped", S_GOVER, 1, 0, 1, 2, 1, 1, 0);
    start = 1'b1;
    cyc(0);
    expect_out("restart", S_SERVE, 1, 0, 1, 0, 0, 0, 0);
    start = 1'b0;

    // Reach PLAY with a nonzero score, then reset asynchronously.
    for (int i = 0; i < SERVE_N; i++) cyc(1);
    expect_out("play_4", S_PLAY, 0, 1, 1, 0, 0, 0, 0);
    cyc(1);
    expect_out("right_miss_3", S_POINT, 1, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < POINT_N; i++) cyc(1);
    for (int i = 0; i < SERVE_N; i++) cyc(1);
    ball_pos_x = 11'd320;
    expect_out("play_5", S_PLAY, 0, 1, 1, 1, 0, 0, 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    // No rising edge occurs before the next check, so only an async reset passes.
    reset = 1'b0;
    expect_out("async_reset", S_IDLE, 1, 0, 1, 0, 0, 0, 0);
    cyc(1);
    expect_out("reset_held", S_IDLE, 1, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;

    // 100 frame ticks after reset release stay in IDLE.
    for (int i = 0; i < 100; i++) cyc(1);
    expect_out("idle_100_ticks", S_IDLE, 1, 0, 1, 0, 0, 0, 0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (exp_q.size() > 0) begin
      miss_cnt++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Game-level sequencer for the ball datapath. It holds the ball at centre while idle, runs a serve countdown, releases the ball for play, and judges paddle misses once per video frame. It keeps the two scores and declares a winner. It sits between the VGA frame timing, the paddle blocks and the `ball` module, driving the ball's hold/run controls and the score display.

## Interface
- BALL_SIZE, 10: ball edge length in pixels; must match the `ball` instance
- LEFT_BOUNDARY, 3: x at or below which the ball is at the left goal line
- RIGHT_BOUNDARY, 637: x at or beyond which the ball's right edge is at the right goal line
- PADDLE_HEIGHT, 64: paddle length in pixels
- SERVE_FRAMES, 60: frame ticks spent in SERVE; must be >= 1
- POINT_FRAMES, 30: frame ticks spent in POINT; must be >= 1
- WIN_SCORE, 7: score that ends the game; range 1..15
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-clk pulse per video frame (end of visible area)
- start  in  1  debounced start button, level
- ball_pos_x  in  11  ball top-left x from `ball`
- ball_pos_y  in  11  ball top-left y from `ball`
- paddle_left_y  in  11  left paddle top y
- paddle_right_y  in  11  right paddle top y
- ball_hold  out  1  1 = `ball` holds position at centre
- ball_run  out  1  1 = `ball` advances on frame ticks
- serve_dir  out  1  0 = serve toward left player, 1 = toward right
- score_left  out  4  left player score
- score_right  out  4  right player score
- state  out  3  encoded FSM state: IDLE=0, SERVE=1, PLAY=2, POINT=3, GAME_OVER=4
- game_over  out  1  1 while in GAME_OVER
- winner  out  1  0 = left player won, 1 = right player won; valid while game_over=1

## Operation
- Start edge detection:
  - start_q registers start.
  - start_edge = start & ~start_q.
  - start_edge is acted on only in IDLE and GAME_OVER; it is ignored in all other states.
- FSM states and transitions:
  - IDLE: ball_hold=1, ball_run=0. On start_edge: go to SERVE and load cnt=SERVE_FRAMES.
  - SERVE: ball_hold=1. Each frame_tick decrements cnt. The frame_tick taken with cnt==1 goes to PLAY, so SERVE lasts exactly SERVE_FRAMES ticks.
  - PLAY: ball_hold=0, ball_run=1. Evaluated only on frame_tick:
    - left_miss = (x <= LEFT_BOUNDARY) & ~ovl(paddle_left_y)
    - right_miss = (x + BALL_SIZE >= RIGHT_BOUNDARY) & ~ovl(paddle_right_y)
    - ovl(p) = (y + BALL_SIZE > p) & (y < p + PADDLE_HEIGHT)
    - All sums are computed at 12 bits; no wrap is allowed.
    - On left_miss: score_right += 1, serve_dir=0, go to POINT, load cnt=POINT_FRAMES.
    - On right_miss: score_left += 1, serve_dir=1, go to POINT, load cnt=POINT_FRAMES.
    - If both misses occur on the same tick, left_miss wins and only one score changes.
    - Ball at a goal line with paddle overlap is a hit: no action, and the ball module bounces.
  - POINT: ball_hold=1. It counts POINT_FRAMES ticks the same way as SERVE. On the final tick:
    - If either score equals WIN_SCORE, go to GAME_OVER and set winner = (score_right == WIN_SCORE).
    - Otherwise go to SERVE and load cnt=SERVE_FRAMES.
  - GAME_OVER: ball_hold=1, game_over=1, and scores stay frozen. On start_edge: clear both scores, set serve_dir=1, go to SERVE, load cnt=SERVE_FRAMES.
- Scores never exceed WIN_SCORE: increments happen only in PLAY, and the game ends on reaching WIN_SCORE.
- ball_hold and ball_run are mutually exclusive in every state.

## Timing
- Every output is a register updated on the rising clk edge.
- Reset values: state=IDLE, ball_hold=1, ball_run=0, serve_dir=1, score_left=0, score_right=0, game_over=0, winner=0, cnt=0, start_q=0.
- Reset asserted mid-game forces these values immediately, without waiting for clk, and holds them until reset deasserts.
- Latency:
  - A qualifying frame_tick or start_edge sampled at edge N makes the new state, scores and hold/run visible after edge N.
  - A score changes on the same edge as the PLAY→POINT transition.
- frame_tick outside SERVE, PLAY and POINT has no effect.
- cnt changes only on frame_tick, or on the load that happens at state entry.
- start held high produces a single start_edge; it must go low and high again to re-trigger.

## Test plan
- Reset and idle: assert reset mid-PLAY with score_left=3 → all outputs return to reset values asynchronously. After release, 100 frame_ticks → state stays IDLE, ball_hold=1.
- Serve countdown: SERVE_FRAMES=4, pulse start → state=SERVE. After exactly 4 frame_ticks, state=PLAY and ball_run=1.
- Miss vs hit, left side: in PLAY, ball_pos_x=3.
  - ball_pos_y=100, paddle_left_y=95, on frame_tick → no change (hit).
  - paddle_left_y=200, on frame_tick → score_right=1, serve_dir=0, state=POINT.
- Miss, right side: ball_pos_x=627, ball_pos_y=50, paddle_right_y=300, on frame_tick → score_left=1, serve_dir=1. After POINT_FRAMES ticks, state=SERVE.
- Game over: WIN_SCORE=2, force two right-side misses → after the second POINT, state=GAME_OVER, game_over=1, winner=0, score_left=2. Further frame_ticks change nothing.
- Restart and edge rule: hold start high through GAME_OVER entry → no restart. Drop start, then raise it → scores 0, serve_dir=1, state=SERVE.
